// File: rtl/best_mv_select_if.sv
// Candidate SAD stream in, per-partition winners out, grouped for the best-MV selector.
// The master side drives the candidates and result_ready; the slave side is the selector.
interface best_mv_select_if #(
  parameter int W8  = 14,
  parameter int W16 = 16,
  parameter int W32 = 18,
  parameter int MVW = 12
);
  logic                search_start;
  logic                sad_valid;
  logic                search_last;
  logic [4:0]          search_column_count;
  logic [6:0]          search_row_count;
  logic [16*W8-1:0]    SAD8x8;
  logic [4*W16-1:0]    SAD16x16;
  logic [W32-1:0]      SAD32x32;
  logic                result_ready;
  logic                result_valid;
  logic [16*W8-1:0]    best_sad8x8;
  logic [16*MVW-1:0]   best_mv8x8;
  logic [4*W16-1:0]    best_sad16x16;
  logic [4*MVW-1:0]    best_mv16x16;
  logic [W32-1:0]      best_sad32x32;
  logic [MVW-1:0]      best_mv32x32;
  logic                busy;
  logic                proto_err;

  modport master (
    output search_start, sad_valid, search_last, search_column_count, search_row_count,
           SAD8x8, SAD16x16, SAD32x32, result_ready,
    input  result_valid, best_sad8x8, best_mv8x8, best_sad16x16, best_mv16x16,
           best_sad32x32, best_mv32x32, busy, proto_err
  );

  modport slave (
    input  search_start, sad_valid, search_last, search_column_count, search_row_count,
           SAD8x8, SAD16x16, SAD32x32, result_ready,
    output result_valid, best_sad8x8, best_mv8x8, best_sad16x16, best_mv16x16,
           best_sad32x32, best_mv32x32, busy, proto_err
  );
endinterface

// File: rtl/best_mv_select.sv
// Tracks the minimum SAD and its MV for 16 8x8, 4 16x16 and one 32x32 partition over a search,
// then holds the winners behind a valid/ready handshake until accepted or a new search starts.
module best_mv_select #(
  parameter int W8  = 14,
  parameter int W16 = 16,
  parameter int W32 = 18,
  parameter int MVW = 12
) (
  input logic           clk,
  input logic           rst,
  best_mv_select_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           take;
  logic [MVW-1:0] cand_mv;
  logic           proto_err;

  logic [W8-1:0]  sad8  [16];
  logic [MVW-1:0] mv8   [16];
  logic [W16-1:0] sad16 [4];
  logic [MVW-1:0] mv16  [4];
  logic [W32-1:0] sad32;
  logic [MVW-1:0] mv32;

  // Strict unsigned compare: a tie keeps the earlier candidate, and an all-ones
  // candidate can never displace the all-ones init value.
  function automatic logic cand_wins(input logic [W32-1:0] cand, input logic [W32-1:0] stored);
    return cand < stored;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.search_start) begin
      state_nxt = SEARCH;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        SEARCH:  if (bus.sad_valid && bus.search_last) state_nxt = HOLD;
        HOLD:    if (bus.result_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy         = (state == SEARCH);
    bus.result_valid = (state == HOLD);
  end

  // A start in the same cycle as a sample wins; the sample is dropped.
  assign take    = bus.sad_valid & ~bus.search_start & (state == SEARCH);
  assign cand_mv = {bus.search_row_count, bus.search_column_count};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          proto_err <= 1'b0;
    else if (bus.search_start)                        proto_err <= 1'b0;
    else if (bus.sad_valid && (state != SEARCH))      proto_err <= 1'b1;
  end

  for (genvar i = 0; i < 16; i++) begin : g_lane8
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sad8[i] <= '1;
        mv8[i]  <= '0;
      end else if (bus.search_start) begin
        sad8[i] <= '1;
        mv8[i]  <= '0;
      end else if (take && cand_wins(W32'(bus.SAD8x8[i*W8 +: W8]), W32'(sad8[i]))) begin
        sad8[i] <= bus.SAD8x8[i*W8 +: W8];
        mv8[i]  <= cand_mv;
      end
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane16
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sad16[i] <= '1;
        mv16[i]  <= '0;
      end else if (bus.search_start) begin
        sad16[i] <= '1;
        mv16[i]  <= '0;
      end else if (take && cand_wins(W32'(bus.SAD16x16[i*W16 +: W16]), W32'(sad16[i]))) begin
        sad16[i] <= bus.SAD16x16[i*W16 +: W16];
        mv16[i]  <= cand_mv;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sad32 <= '1;
      mv32  <= '0;
    end else if (bus.search_start) begin
      sad32 <= '1;
      mv32  <= '0;
    end else if (take && cand_wins(bus.SAD32x32, sad32)) begin
      sad32 <= bus.SAD32x32;
      mv32  <= cand_mv;
    end
  end

  always_comb begin
    bus.best_sad8x8   = '0;
    bus.best_mv8x8    = '0;
    bus.best_sad16x16 = '0;
    bus.best_mv16x16  = '0;
    for (int i = 0; i < 16; i++) begin
      bus.best_sad8x8[i*W8 +: W8]  = sad8[i];
      bus.best_mv8x8[i*MVW +: MVW] = mv8[i];
    end
    for (int i = 0; i < 4; i++) begin
      bus.best_sad16x16[i*W16 +: W16] = sad16[i];
      bus.best_mv16x16[i*MVW +: MVW]  = mv16[i];
    end
    bus.best_sad32x32 = sad32;
    bus.best_mv32x32  = mv32;
  end

  assign bus.proto_err = proto_err;

endmodule

// File: tb/tb_best_mv_select.sv
// Directed bench for best_mv_select: a search-level reference model checked every cycle,
// plus hand-computed literal expectations at the key points of each scenario.
module tb_best_mv_select;
  localparam int W8  = 14;
  localparam int W16 = 16;
  localparam int W32 = 18;
  localparam int MVW = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  best_mv_select_if bi ();
  best_mv_select dut (.clk(clk), .rst(rst), .bus(bi));

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [223:0] act, input logic [223:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: 0 = no search running, 1 = collecting candidates, 2 = result pending.
  int             m_mode;
  bit             m_proto;
  logic [W8-1:0]  m_s8  [16];
  logic [MVW-1:0] m_v8  [16];
  logic [W16-1:0] m_s16 [4];
  logic [MVW-1:0] m_v16 [4];
  logic [W32-1:0] m_s32;
  logic [MVW-1:0] m_v32;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode  <= 0;
      m_proto <= 1'b0;
      for (int i = 0; i < 16; i++) begin m_s8[i] <= '1; m_v8[i] <= '0; end
      for (int i = 0; i < 4; i++)  begin m_s16[i] <= '1; m_v16[i] <= '0; end
      m_s32 <= '1;
      m_v32 <= '0;
    end else if (bi.search_start) begin
      m_mode  <= 1;
      m_proto <= 1'b0;
      for (int i = 0; i < 16; i++) begin m_s8[i] <= '1; m_v8[i] <= '0; end
      for (int i = 0; i < 4; i++)  begin m_s16[i] <= '1; m_v16[i] <= '0; end
      m_s32 <= '1;
      m_v32 <= '0;
    end else begin
      if (bi.sad_valid && m_mode != 1) m_proto <= 1'b1;
      if (bi.sad_valid && m_mode == 1) begin
        for (int i = 0; i < 16; i++)
          if (bi.SAD8x8[i*W8 +: W8] < m_s8[i]) begin
            m_s8[i] <= bi.SAD8x8[i*W8 +: W8];
            m_v8[i] <= {bi.search_row_count, bi.search_column_count};
          end
        for (int i = 0; i < 4; i++)
          if (bi.SAD16x16[i*W16 +: W16] < m_s16[i]) begin
            m_s16[i] <= bi.SAD16x16[i*W16 +: W16];
            m_v16[i] <= {bi.search_row_count, bi.search_column_count};
          end
        if (bi.SAD32x32 < m_s32) begin
          m_s32 <= bi.SAD32x32;
          m_v32 <= {bi.search_row_count, bi.search_column_count};
        end
        if (bi.search_last) m_mode <= 2;
      end
      if (m_mode == 2 && bi.result_ready) m_mode <= 0;
    end
  end

  logic [16*W8-1:0]  e_s8;
  logic [16*MVW-1:0] e_v8;
  logic [4*W16-1:0]  e_s16;
  logic [4*MVW-1:0]  e_v16;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 16; i++) begin
        e_s8[i*W8 +: W8]   = m_s8[i];
        e_v8[i*MVW +: MVW] = m_v8[i];
      end
      for (int i = 0; i < 4; i++) begin
        e_s16[i*W16 +: W16] = m_s16[i];
        e_v16[i*MVW +: MVW] = m_v16[i];
      end
      chk("result_valid", 224'(bi.result_valid), 224'(m_mode == 2));
      chk("busy",         224'(bi.busy),         224'(m_mode == 1));
      chk("proto_err",    224'(bi.proto_err),    224'(m_proto));
      chk("best_sad8x8",  224'(bi.best_sad8x8),  224'(e_s8));
      chk("best_mv8x8",   224'(bi.best_mv8x8),   224'(e_v8));
      chk("best_sad16x16", 224'(bi.best_sad16x16), 224'(e_s16));
      chk("best_mv16x16", 224'(bi.best_mv16x16), 224'(e_v16));
      chk("best_sad32x32", 224'(bi.best_sad32x32), 224'(m_s32));
      chk("best_mv32x32", 224'(bi.best_mv32x32), 224'(m_v32));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bi.search_start        = 1'b0;
    bi.sad_valid           = 1'b0;
    bi.search_last         = 1'b0;
    bi.search_column_count = '0;
    bi.search_row_count    = '0;
    bi.SAD8x8              = '1;
    bi.SAD16x16            = '1;
    bi.SAD32x32            = '1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin step(); clear_in(); end
  endtask

  task automatic start();
    step(); clear_in();
    bi.search_start = 1'b1;
  endtask

  task automatic sample(input logic [4:0] c, input logic [6:0] r, input logic [16*W8-1:0] s8,
                        input logic [4*W16-1:0] s16, input logic [W32-1:0] s32, input bit last);
    step(); clear_in();
    bi.sad_valid           = 1'b1;
    bi.search_last         = last;
    bi.search_column_count = c;
    bi.search_row_count    = r;
    bi.SAD8x8              = s8;
    bi.SAD16x16            = s16;
    bi.SAD32x32            = s32;
  endtask

  function automatic logic [16*W8-1:0] rnd8();
    logic [16*W8-1:0] v;
    for (int i = 0; i < 16; i++)
      v[i*W8 +: W8] = ($urandom_range(0, 7) == 0) ? {W8{1'b1}} : W8'($urandom_range(0, 400));
    return v;
  endfunction

  function automatic logic [4*W16-1:0] rnd16();
    logic [4*W16-1:0] v;
    for (int i = 0; i < 4; i++) v[i*W16 +: W16] = W16'($urandom_range(0, 1500));
    return v;
  endfunction

  logic [16*W8-1:0]  ones8;
  logic [4*W16-1:0]  ones16;
  logic [16*W8-1:0]  v8;
  logic [4*W16-1:0]  v16;

  initial begin
    ones8  = '1;
    ones16 = '1;
    clear_in();
    bi.result_ready = 1'b0;
    #2;
    rst    = 1'b1;
    chk_en = 1'b1;
    idle(3);
    chk("rst_valid", 224'(bi.result_valid), 224'(0));
    chk("rst_sad32", 224'(bi.best_sad32x32), 224'(18'h3FFFF));
    chk("rst_mv8",   224'(bi.best_mv8x8), 224'(0));
    step(); clear_in(); rst = 1'b0;

    // Lane 0 sees 100, 50, 50: first 50 at (c3,r4) wins the tie.
    start();
    sample(5'd1, 7'd2, {ones8[16*W8-1:W8], 14'd100}, {ones16[4*W16-1:W16], 16'd300}, 18'h3FFFF, 1'b0);
    sample(5'd3, 7'd4, {ones8[16*W8-1:W8], 14'd50},  {ones16[4*W16-1:W16], 16'd200}, 18'h3FFFF, 1'b0);
    sample(5'd5, 7'd6, {ones8[16*W8-1:W8], 14'd50},  {ones16[4*W16-1:W16], 16'd200}, 18'h3FFFF, 1'b1);
    idle(1);
    chk("t1_valid",  224'(bi.result_valid), 224'(1));
    chk("t1_busy",   224'(bi.busy), 224'(0));
    chk("t1_sad8_0", 224'(bi.best_sad8x8[13:0]), 224'(50));
    chk("t1_mv8_0",  224'(bi.best_mv8x8[11:0]), 224'(12'h083));
    chk("t1_sad8_1", 224'(bi.best_sad8x8[27:14]), 224'(14'h3FFF));
    chk("t1_sad16_0", 224'(bi.best_sad16x16[15:0]), 224'(200));
    chk("t1_mv16_0", 224'(bi.best_mv16x16[11:0]), 224'(12'h083));
    chk("t1_sad32",  224'(bi.best_sad32x32), 224'(18'h3FFFF));
    chk("t1_mv32",   224'(bi.best_mv32x32), 224'(0));

    // Backpressure, then accept.
    idle(5);
    chk("hold_valid", 224'(bi.result_valid), 224'(1));
    chk("hold_sad8_0", 224'(bi.best_sad8x8[13:0]), 224'(50));
    step(); clear_in(); bi.result_ready = 1'b1;
    step(); clear_in(); bi.result_ready = 1'b0;
    chk("acc_valid", 224'(bi.result_valid), 224'(0));
    chk("acc_busy",  224'(bi.busy), 224'(0));
    chk("acc_sad8_0", 224'(bi.best_sad8x8[13:0]), 224'(50));

    // Stray sample in IDLE.
    sample(5'd9, 7'd9, {ones8[16*W8-1:W8], 14'd1}, ones16, 18'd1, 1'b0);
    idle(1);
    chk("idle_proto", 224'(bi.proto_err), 224'(1));
    chk("idle_sad8_0", 224'(bi.best_sad8x8[13:0]), 224'(50));

    start();
    idle(1);
    chk("start_proto", 224'(bi.proto_err), 224'(0));
    chk("start_busy",  224'(bi.busy), 224'(1));
    chk("start_sad8",  224'(bi.best_sad8x8), 224'(ones8));

    // search_last alone does nothing.
    step(); clear_in(); bi.search_last = 1'b1;
    idle(1);
    chk("last_only_busy", 224'(bi.busy), 224'(1));

    sample(5'd2, 7'd3, {ones8[16*W8-1:W8], 14'd7}, ones16, 18'd77, 1'b1);
    idle(1);
    chk("t2_valid", 224'(bi.result_valid), 224'(1));
    chk("t2_sad8_0", 224'(bi.best_sad8x8[13:0]), 224'(7));
    chk("t2_sad32",  224'(bi.best_sad32x32), 224'(77));

    // Abort in HOLD with a colliding sample.
    step(); clear_in();
    bi.search_start = 1'b1;
    bi.sad_valid    = 1'b1;
    bi.SAD8x8       = {ones8[16*W8-1:W8], 14'd5};
    idle(1);
    chk("abort_valid", 224'(bi.result_valid), 224'(0));
    chk("abort_busy",  224'(bi.busy), 224'(1));
    chk("abort_sad8",  224'(bi.best_sad8x8), 224'(ones8));
    chk("abort_sad32", 224'(bi.best_sad32x32), 224'(18'h3FFFF));

    // Ten samples, then reset mid-search.
    for (int k = 0; k < 10; k++) begin
      v8 = rnd8(); v16 = rnd16();
      sample(5'(k), 7'(k + 1), v8, v16, W32'($urandom_range(0, 5000)), 1'b0);
    end
    step(); clear_in(); rst = 1'b1;
    step(); clear_in();
    chk("mrst_busy",  224'(bi.busy), 224'(0));
    chk("mrst_valid", 224'(bi.result_valid), 224'(0));
    chk("mrst_sad8",  224'(bi.best_sad8x8), 224'(ones8));
    chk("mrst_mv16",  224'(bi.best_mv16x16), 224'(0));
    chk("mrst_proto", 224'(bi.proto_err), 224'(0));
    rst = 1'b0;

    // Full 32x64 sweep.
    start();
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 32; c++) begin
        v8 = rnd8(); v16 = rnd16();
        sample(5'(c), 7'(r), v8, v16, W32'($urandom_range(0, 20000)), (r == 63) && (c == 31));
      end
    idle(1);
    chk("sweep_valid", 224'(bi.result_valid), 224'(1));
    step(); clear_in(); bi.result_ready = 1'b1;
    step(); clear_in(); bi.result_ready = 1'b0;
    chk("sweep_acc_valid", 224'(bi.result_valid), 224'(0));
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
